// File: rtl/vid_pkg.sv
// Shared types and constants for the video raster controller and its register block.
package vid_pkg;

    localparam int CNT_W          = 13;
    localparam int PDIV_W         = 6;
    localparam int FIFO_THRESHOLD = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } raster_state_t;

    typedef struct packed {
        logic [CNT_W-1:0] hend;
        logic [CNT_W-1:0] hsize;
    } h1_t;

    typedef struct packed {
        logic [CNT_W-1:0] hsync_end;
        logic [CNT_W-1:0] hsync_start;
    } h2_t;

    typedef struct packed {
        logic [CNT_W-1:0] vend;
        logic [CNT_W-1:0] vsize;
    } v1_t;

    typedef struct packed {
        logic [CNT_W-1:0] vsync_end;
        logic [CNT_W-1:0] vsync_start;
    } v2_t;

    // Half-open window test used by both sync decoders.
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage

// File: rtl/vid_pix_div.sv
// Pixel clock divider: one-cycle tick every (pcnt+1) enabled clk cycles.
module vid_pix_div #(
    parameter int PDIV_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              clr,
    input  logic [PDIV_W-1:0] pcnt,
    output logic              tick
);

    logic [PDIV_W-1:0] div_cnt;

    // Down-counter preloaded with the period so the first tick lands pcnt cycles after clr.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= pcnt;
        end else if (en) begin
            div_cnt <= (div_cnt == '0) ? pcnt : div_cnt - 1'b1;
        end
    end

    assign tick = en && (div_cnt == '0);

endmodule

// File: rtl/vid_raster_ctrl.sv
// Raster timing generator and RGB FIFO read sequencer with one-line-ahead fetch requests.
//   state | meaning
//   IDLE  | stopped, blanking asserted, waiting for en
//   PRIME | line 0 requested, waiting for ack and then for FIFO threshold
//   RUN   | raster running, FIFO reads and line fetches active
//   DRAIN | raster running to end of frame, reads and new fetches suppressed
module vid_raster_ctrl #(
    parameter int CNT_W  = vid_pkg::CNT_W,
    parameter int PDIV_W = vid_pkg::PDIV_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [PDIV_W-1:0] pcnt,
    input  logic [CNT_W-1:0]  hsize,
    input  logic [CNT_W-1:0]  hend,
    input  logic [CNT_W-1:0]  hsync_start,
    input  logic [CNT_W-1:0]  hsync_end,
    input  logic [CNT_W-1:0]  vsize,
    input  logic [CNT_W-1:0]  vend,
    input  logic [CNT_W-1:0]  vsync_start,
    input  logic [CNT_W-1:0]  vsync_end,
    input  logic              fifo_empty,
    input  logic              fifo_threshold,
    output logic              fifo_rd,
    output logic              pix_valid,
    output logic              hsync,
    output logic              hblank,
    output logic              vsync,
    output logic              vblank,
    output logic              line_req,
    output logic [CNT_W-1:0]  line_idx,
    input  logic              line_ack,
    output logic              underflow,
    output logic              fetch_overrun,
    output logic              busy
);
    import vid_pkg::*;

    raster_state_t     state;
    raster_state_t     state_nxt;

    h1_t               h1_s;
    h2_t               h2_s;
    v1_t               v1_s;
    v2_t               v2_s;
    logic [PDIV_W-1:0] pcnt_s;

    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  vcnt;
    logic [CNT_W-1:0]  nxt_line;

    logic              tick;
    logic              raster_on;
    logic              decode_on;
    logic              start_prime;
    logic              eol;
    logic              eof;
    logic              active;
    logic              rd_slot;
    logic              due_row;
    logic              due_eof;
    logic              req_due;
    logic [CNT_W-1:0]  req_idx;

    assign raster_on   = (state == RUN) || (state == DRAIN);
    assign decode_on   = (state_nxt == RUN) || (state_nxt == DRAIN);
    assign start_prime = (state == IDLE) && (state_nxt == PRIME);
    assign eol         = (hcnt == h1_s.hend);
    assign eof         = eol && (vcnt == v1_s.vend);
    assign active      = (hcnt < h1_s.hsize) && (vcnt < v1_s.vsize);
    assign busy        = (state != IDLE);

    vid_pix_div #(
        .PDIV_W (PDIV_W)
    ) u_pix_div (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (raster_on),
        .clr     (!raster_on),
        .pcnt    (pcnt_s),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A PRIME exit (either way) waits for the line 0 request to be acked so no request is orphaned.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (en && !line_req) begin
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                if (!line_req) begin
                    if (!en) begin
                        state_nxt = IDLE;
                    end else if (fifo_threshold) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = (tick && eof) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (tick && eof) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h1_s   <= '0;
            h2_s   <= '0;
            v1_s   <= '0;
            v2_s   <= '0;
            pcnt_s <= '0;
        end else if (start_prime) begin
            h1_s.hsize       <= hsize;
            h1_s.hend        <= hend;
            h2_s.hsync_start <= hsync_start;
            h2_s.hsync_end   <= hsync_end;
            v1_s.vsize       <= vsize;
            v1_s.vend        <= vend;
            v2_s.vsync_start <= vsync_start;
            v2_s.vsync_end   <= vsync_end;
            pcnt_s           <= pcnt;
        end
    end

    // Wrap on equality: from 0 the counters always reach the end value, even with an illegal config.
    always_ff @(posedge clk) begin
        if (!reset_n || !raster_on) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (tick) begin
            if (eol) begin
                hcnt <= '0;
                vcnt <= (vcnt == v1_s.vend) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hblank <= 1'b1;
            vblank <= 1'b1;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
        end else if (decode_on) begin
            hblank <= !(hcnt < h1_s.hsize);
            vblank <= !(vcnt < v1_s.vsize);
            hsync  <= in_window(hcnt, h2_s.hsync_start, h2_s.hsync_end);
            vsync  <= in_window(vcnt, v2_s.vsync_start, v2_s.vsync_end);
        end else begin
            hblank <= 1'b1;
            vblank <= 1'b1;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
        end
    end

    assign rd_slot   = (state == RUN) && tick && active;
    assign fifo_rd   = rd_slot && !fifo_empty;
    assign pix_valid = fifo_rd;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            underflow <= 1'b0;
        end else if (rd_slot && fifo_empty) begin
            underflow <= 1'b1;
        end
    end

    // A RUN cycle with en low is leaving RUN, so it issues no new fetch.
    assign nxt_line = vcnt + 1'b1;
    assign due_row  = (state == RUN) && en && tick && (hcnt == h1_s.hsize) && (nxt_line < v1_s.vsize);
    assign due_eof  = (state == RUN) && en && tick && eof;
    assign req_due  = start_prime || due_row || due_eof;
    assign req_idx  = (start_prime || due_eof) ? '0 : nxt_line;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line_req      <= 1'b0;
            line_idx      <= '0;
            fetch_overrun <= 1'b0;
        end else if (req_due) begin
            if (line_req && !line_ack) begin
                fetch_overrun <= 1'b1;
            end else begin
                line_req <= 1'b1;
                line_idx <= req_idx;
            end
        end else if (line_ack) begin
            line_req <= 1'b0;
        end
    end

endmodule
